dffram_arbiter: RTL
===================

# dffram_arbiter

Two-port arbiter that shares one single-port 128x32 DFFRAM macro between two requesters (port A, port B), e.g. a CPU data port and a DMA engine. It sequences RAM enables and byte write-enables, grants one access per cycle, routes one-cycle-latency read data back to the issuing port, and holds each port's last read word. It sits directly in front of the DFFRAM instance, which sees a single requester.

## Interface
Parameters:
- AW, 7, RAM word-address width (128 words).
- DW, 32, data width; byte lanes = DW/8.
- BURST, 4, maximum consecutive grants to one port while the other requests (1..15).

Ports (clock and reset first):
- CLK  in  1  single clock; all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ_A / REQ_B  in  1  port request; qualifies WE/A/DI of that port.
- WE_A / WE_B  in  DW/8  byte write-enables; all zero = read.
- A_A / A_B  in  AW  word address.
- DI_A / DI_B  in  DW  write data.
- GNT_A / GNT_B  out  1  access accepted this cycle (combinational from REQ and state).
- RVALID_A / RVALID_B  out  1  read data valid, one cycle after a granted read.
- DO_A / DO_B  out  DW  read data; held until that port's next read returns.
- RAM_EN  out  1  to DFFRAM EN0.
- RAM_WE  out  DW/8  to DFFRAM WE0.
- RAM_A  out  AW  to DFFRAM A0.
- RAM_DI  out  DW  to DFFRAM Di0.
- RAM_DO  in  DW  from DFFRAM Do0.

## Operation
- Handshake: a transfer occurs when REQx && GNTx in the same cycle. A requester keeps REQ/WE/A/DI stable until GNT. At most one GNT per cycle.
- RAM drive: RAM_EN = GNT_A|GNT_B; RAM_WE/A/DI muxed from granted port; RAM_WE = 0 when no grant.
- Arbitration state: LAST (port granted most recently, reset A) and RUN (4-bit consecutive-grant count, reset 0).
- Only one port requesting: it is granted every cycle regardless of RUN.
- Both requesting: LAST keeps grant while RUN < BURST; when RUN == BURST the other port is granted.
- On each grant: same port as LAST -> RUN+1 (saturates at 15); other port -> LAST switches, RUN = 1. No grant -> RUN = 0, LAST unchanged.
- Read tracking: registered RD_OWN (none/A/B) set on a granted read (WE all zero). Next cycle RVALID of that owner = 1 and DO of that owner is loaded from RAM_DO; other port's DO unchanged.
- Writes produce no RVALID. Partial byte writes pass WE unchanged.
- Back-to-back reads from alternating ports are allowed; each RVALID lands exactly one cycle after its grant.

## Timing
- Reset values: GNT_A/B 0 (while REQ low), RVALID_A/B 0, DO_A/B 0, RAM_EN 0, RAM_WE 0, LAST = A, RUN = 0, RD_OWN = none.
- Grant latency 0 cycles (same-cycle). Read latency: grant in cycle N -> RVALID and DO valid in cycle N+1.
- Throughput: one access per cycle aggregate.
- Reset asserted mid-read: pending RVALID is dropped; DO cleared to 0.
- Simultaneous REQ_A and REQ_B from reset: A granted first.

## Configuration
- DFFRAM_ARB_FAIR_EN defined: BURST-bounded rotation as above.
- Not defined: fixed priority, port A always wins when both request; LAST/RUN logic removed, BURST ignored.

## Structure
- Shared package dffram_pkg: AW/DW defaults, owner encoding (OWN_NONE, OWN_A, OWN_B), byte-lane count constant.
- One sub-module natural: dffram_arb_core (grant + LAST/RUN logic); datapath mux and DO registers stay in the top.

## Test plan
- Reset, then A writes 0xDEADBEEF to addr 5 (WE=4'hF), then A reads 5 -> GNT_A same cycle, RVALID_A next cycle, DO_A = 0xDEADBEEF; DO_B stays 0.
- A writes 0x11223344 to addr 9, B writes WE=4'b0010 data 0x0000AA00 to 9, A reads 9 -> DO_A = 0x1122AA44.
- Both request continuously, BURST=4, FAIR_EN on -> grant pattern A,A,A,A,B,B,B,B,A...; with FAIR_EN off -> A every cycle, GNT_B never.
- Alternating reads A(addr1), B(addr2) back-to-back -> RVALID_A then RVALID_B in consecutive cycles, each with the correct word; no cross-routing.
- Assert RST_N low in the cycle after a granted read -> RVALID stays 0, DO_x = 0, next grant goes to A.
- Only B requests for 20 cycles with FAIR_EN on -> B granted every cycle, RUN saturates at 15 without wrap.

Source files
------------

// File: rtl/dffram_pkg.sv
// dffram_pkg
// Shared constants and types for the DFFRAM two-port arbiter.
//   DEF_AW / DEF_DW  default RAM word-address and data widths (128 x 32)
//   DEF_LANES        byte lanes per word (byte write-enable width)
//   DEF_BURST        default consecutive-grant bound for the fair mode
//   RUN_MAX          saturation value of the 4-bit consecutive-grant count
//   own_t            owner of the read currently in flight
package dffram_pkg;

  localparam int DEF_AW    = 7;
  localparam int DEF_DW    = 32;
  localparam int DEF_LANES = DEF_DW / 8;
  localparam int DEF_BURST = 4;

  localparam logic [3:0] RUN_MAX = 4'd15;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } own_t;

endpackage

// File: rtl/dffram_arb_core.sv
// dffram_arb_core
// Grant logic for the two requesters. Grants are combinational from the
// requests and the arbitration state; at most one grant per cycle.
// Build option DFFRAM_ARB_FAIR_EN:
//   defined     - the most recently granted port keeps the grant while its
//                 consecutive-grant count is below BURST, then yields.
//   not defined - fixed priority, port A wins whenever both request.
// Ports:
//   CLK, RST_N      clock, asynchronous active-low reset
//   req_a, req_b    port requests
//   gnt_a, gnt_b    one-hot (or zero) grant
module dffram_arb_core
  import dffram_pkg::*;
#(
  parameter int BURST = DEF_BURST
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

`ifdef DFFRAM_ARB_FAIR_EN
  localparam logic [3:0] BURST_L = 4'(BURST);

  // last_b: 0 = port A granted most recently, 1 = port B
  logic       last_b;
  logic [3:0] run;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (req_a && req_b) begin
      // run can exceed BURST after a long single-port stretch; yield then too
      if (run >= BURST_L) begin
        gnt_a = last_b;
        gnt_b = ~last_b;
      end else begin
        gnt_a = ~last_b;
        gnt_b = last_b;
      end
    end else begin
      gnt_a = req_a;
      gnt_b = req_b;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_b <= 1'b0;
      run    <= 4'd0;
    end else if (gnt_a || gnt_b) begin
      if (gnt_b == last_b) begin
        run <= (run == RUN_MAX) ? run : run + 4'd1;
      end else begin
        last_b <= gnt_b;
        run    <= 4'd1;
      end
    end else begin
      run <= 4'd0;
    end
  end
`else
  // No arbitration state in fixed-priority mode.
  logic unused_core;
  assign unused_core = CLK ^ RST_N ^ (^BURST);

  always_comb begin
    gnt_a = req_a;
    gnt_b = req_b & ~req_a;
  end
`endif

endmodule

// File: rtl/dffram_arbiter.sv
// dffram_arbiter
// Shares one single-port 128x32 DFFRAM macro between two requesters.
// One access per cycle; read data returns one cycle after the grant and is
// steered to the issuing port, whose DO then holds it until its next read.
// Build option DFFRAM_ARB_FAIR_EN selects BURST-bounded rotation instead of
// fixed A-priority (see dffram_arb_core).
// Ports:
//   CLK, RST_N                     clock, asynchronous active-low reset
//   REQ_x, WE_x, A_x, DI_x         requester x command (x = A, B)
//   GNT_x                          command accepted this cycle
//   RVALID_x, DO_x                 read return for requester x
//   RAM_EN, RAM_WE, RAM_A, RAM_DI  drive to the DFFRAM macro
//   RAM_DO                         macro read data (one-cycle latency)
module dffram_arbiter
  import dffram_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int BURST = DEF_BURST
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            REQ_A,
  input  logic [DW/8-1:0] WE_A,
  input  logic [AW-1:0]   A_A,
  input  logic [DW-1:0]   DI_A,
  input  logic            REQ_B,
  input  logic [DW/8-1:0] WE_B,
  input  logic [AW-1:0]   A_B,
  input  logic [DW-1:0]   DI_B,
  output logic            GNT_A,
  output logic            GNT_B,
  output logic            RVALID_A,
  output logic            RVALID_B,
  output logic [DW-1:0]   DO_A,
  output logic [DW-1:0]   DO_B,
  output logic            RAM_EN,
  output logic [DW/8-1:0] RAM_WE,
  output logic [AW-1:0]   RAM_A,
  output logic [DW-1:0]   RAM_DI,
  input  logic [DW-1:0]   RAM_DO
);

  own_t          rd_own;
  logic [DW-1:0] do_a_q;
  logic [DW-1:0] do_b_q;

  dffram_arb_core #(
    .BURST (BURST)
  ) u_core (
    .CLK   (CLK),
    .RST_N (RST_N),
    .req_a (REQ_A),
    .req_b (REQ_B),
    .gnt_a (GNT_A),
    .gnt_b (GNT_B)
  );

  always_comb begin
    RAM_EN = GNT_A | GNT_B;
    RAM_WE = '0;
    RAM_A  = A_A;
    RAM_DI = DI_A;
    if (GNT_A) begin
      RAM_WE = WE_A;
    end else if (GNT_B) begin
      RAM_WE = WE_B;
      RAM_A  = A_B;
      RAM_DI = DI_B;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_own <= OWN_NONE;
    end else if (GNT_A) begin
      rd_own <= (WE_A == '0) ? OWN_A : OWN_NONE;
    end else if (GNT_B) begin
      rd_own <= (WE_B == '0) ? OWN_B : OWN_NONE;
    end else begin
      rd_own <= OWN_NONE;
    end
  end

  assign RVALID_A = (rd_own == OWN_A);
  assign RVALID_B = (rd_own == OWN_B);

  // The macro output is only meaningful in the cycle after a read, so DO
  // passes it straight through then and captures it for the hold period.
  assign DO_A = RVALID_A ? RAM_DO : do_a_q;
  assign DO_B = RVALID_B ? RAM_DO : do_b_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      do_a_q <= '0;
      do_b_q <= '0;
    end else begin
      do_a_q <= DO_A;
      do_b_q <= DO_B;
    end
  end

endmodule
